// File: rtl/fetch_if.sv
// Fetch-stage bus: instruction-memory read port, redirect input and decode-side valid/ready output.
// master = fetch_unit, slave = the memory/decode environment.
interface fetch_if #(
    parameter int ADDR_W  = 4,
    parameter int INSTR_W = 16
);
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_instr;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_target;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [ADDR_W-1:0]  out_pc;
    logic               halted;
    logic [7:0]         fetch_count;

    modport master (
        output imem_addr,
        input  imem_instr,
        input  redirect_valid,
        input  redirect_target,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc,
        output halted,
        output fetch_count
    );

    modport slave (
        input  imem_addr,
        output imem_instr,
        output redirect_valid,
        output redirect_target,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc,
        input  halted,
        input  fetch_count
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads the combinational imem, presents words to decode.
// Optional halt-on-zero-word behaviour is enabled by defining FETCH_HALT_ON_ZERO_EN.
module fetch_unit #(
    parameter int                ADDR_W   = 4,
    parameter int                INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic     clk,
    input  logic     rst_n,
    fetch_if.master  bus,
    output logic     state_dbg
);
    typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

    state_t             state;
    logic [ADDR_W-1:0]  pc;
    logic               out_valid_q;
    logic [INSTR_W-1:0] out_instr_q;
    logic [ADDR_W-1:0]  out_pc_q;
    logic [7:0]         fetch_count_q;

    // Handshake: a word moves to decode on a rising edge where out_valid && out_ready.
    // While out_valid is high and out_ready low, out_instr/out_pc hold; out_valid only
    // drops without a transfer on redirect or reset.
    logic transfer;
    logic slot_free;

    assign transfer  = out_valid_q & bus.out_ready;
    assign slot_free = ~out_valid_q | bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= RUN;
            pc            <= RESET_PC;
            out_valid_q   <= 1'b0;
            out_instr_q   <= '0;
            out_pc_q      <= '0;
            fetch_count_q <= '0;
        end else begin
            if (transfer && fetch_count_q != 8'hFF)
                fetch_count_q <= fetch_count_q + 8'd1;

            // Redirect wins over fetch and stall; the held word is flushed, not delivered.
            if (bus.redirect_valid) begin
                pc          <= bus.redirect_target;
                out_valid_q <= 1'b0;
                state       <= RUN;
            end else if (state == RUN && slot_free) begin
`ifdef FETCH_HALT_ON_ZERO_EN
                if (bus.imem_instr == '0) begin
                    state       <= HALTED;
                    out_valid_q <= 1'b0;
                end else begin
                    out_instr_q <= bus.imem_instr;
                    out_pc_q    <= pc;
                    out_valid_q <= 1'b1;
                    pc          <= pc + ADDR_W'(1);
                end
`else
                out_instr_q <= bus.imem_instr;
                out_pc_q    <= pc;
                out_valid_q <= 1'b1;
                pc          <= pc + ADDR_W'(1);
`endif
            end
        end
    end

    assign bus.imem_addr   = pc;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_instr   = out_instr_q;
    assign bus.out_pc      = out_pc_q;
    assign bus.fetch_count = fetch_count_q;
    assign state_dbg       = state;

`ifdef FETCH_HALT_ON_ZERO_EN
    assign bus.halted = (state == HALTED);
`else
    assign bus.halted = 1'b0;
`endif
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that owns the program counter and drives the read address of the 16-entry, 16-bit combinational instruction memory. It captures the returned word into an output register and hands it to the decode stage over a valid/ready handshake. It also supports control-flow redirects and optional halt-on-zero-word. The block sits directly upstream of the instruction memory and directly upstream of decode.

## Interface
- ADDR_W, 4, PC / instruction-memory address width
- INSTR_W, 16, instruction width
- RESET_PC, 0, PC value loaded on reset
- clk  in  1  single system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- imem_addr  out  ADDR_W  read address to instruction memory; always equals the internal PC
- imem_instr  in  INSTR_W  combinational instruction-memory data for imem_addr
- redirect_valid  in  1  load a new PC this cycle (branch/jump)
- redirect_target  in  ADDR_W  new PC when redirect_valid=1
- out_valid  out  1  out_instr/out_pc hold a fetched instruction
- out_ready  in  1  decode accepts the word this cycle
- out_instr  out  INSTR_W  fetched instruction
- out_pc  out  ADDR_W  address out_instr was fetched from
- halted  out  1  fetch stopped on a halt word
- fetch_count  out  8  number of words handed to decode; saturates at 255

## Operation
- State machine:
  - RUN: normal fetch.
  - HALTED: PC frozen; out_valid=0.
- A transfer occurs on a rising edge with out_valid=1 and out_ready=1. The slot is free when out_valid=0 or a transfer occurs.
- RUN, no redirect, slot free:
  - out_instr<=imem_instr, out_pc<=pc, out_valid<=1.
  - pc<=pc+1, modulo 2^ADDR_W, so 15 wraps to 0.
- RUN, no redirect, slot not free (out_valid=1, out_ready=0): pc, out_instr, out_pc and out_valid all hold.
- Redirect (any state) has priority over fetch and stall:
  - pc<=redirect_target and out_valid<=0, which flushes the held word.
  - A transfer completing in the same cycle still counts.
  - state<=RUN.
  - The target word is presented on the following edge, which is a one-cycle bubble.
- fetch_count increments by 1 on each transfer and holds at 255.
- Halt, with FETCH_HALT_ON_ZERO_EN:
  - In RUN with the slot free, imem_instr==0 is not captured.
  - state<=HALTED, halted<=1, out_valid<=0, and pc stays on the zero word's address.
  - Only a redirect or reset leaves HALTED; halted clears on that same edge.
- Reset values, applied asynchronously:
  - pc=RESET_PC, imem_addr=RESET_PC, state=RUN.
  - out_valid=0, out_instr=0, out_pc=0, halted=0, fetch_count=0.

## Timing
- imem_addr is a pure register output; there is no combinational path from any input.
- Latency, reset release to first valid: out_valid=1 after the first rising edge following rst_n deassertion, carrying the word at RESET_PC.
- Steady-state throughput is 1 word per cycle while out_ready=1.
- Redirect penalty is 1 cycle: redirect at edge N gives the target word valid after edge N+1.
- The handshake is AXI-style:
  - out_instr and out_pc are stable while out_valid=1 and out_ready=0.
  - out_valid never drops without a transfer, except on redirect or reset.
- rst_n assertion mid-operation forces all reset values immediately, regardless of clk.

## Configuration
- FETCH_HALT_ON_ZERO_EN defined:
  - The all-zero word halts fetch as described in Operation.
  - halted is driven by the state machine.
- FETCH_HALT_ON_ZERO_EN undefined:
  - The HALTED state is not present.
  - Zero words are fetched and presented like any other word.
  - halted is tied to 0.

## Test plan
All scenarios use a memory image of addr0=16'hA00A, addr1=16'h5005, addr2=16'h6006, addr3=16'h0A50, addr4=16'h06A0, and addr5..15=0.
- Reset then out_ready=1, macro enabled:
  - Words A00A, 5005, 6006, 0A50, 06A0 appear with out_pc 0..4 on consecutive cycles.
  - Next cycle out_valid=0, halted=1, imem_addr=5; fetch_count=5.
- Backpressure: hold out_ready=0 for 3 cycles while out_instr=5005.
  - out_instr/out_pc (5005/1) stay stable and imem_addr stays 2.
  - On release, 6006 follows on the next cycle.
- Redirect: assert redirect_valid with target=3 while out_instr=5005 is stalled.
  - Next cycle out_valid=0.
  - The cycle after, out_instr=0A50 and out_pc=3; 5005 is never counted.
- Halt exit: while halted, redirect to 0.
  - halted=0 and A00A is valid two edges later.
- Macro undefined, free run:
  - Zero words at out_pc 5..15 are presented, then out_pc wraps to 0 with A00A.
  - halted stays 0.
- Async reset asserted mid-stream between clock edges:
  - out_valid, out_instr, fetch_count and halted go to 0 and imem_addr goes to 0 immediately.
  - Then run 300 transfers: fetch_count=255.
